// File: rtl/txpu_gen2_if.sv
// Byte-transmitter link used by txpu_gen2: byte/valid/ready handshake plus EOP request/done.
interface txpu_gen2_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       eop;
    logic       eop_done;

    modport master (output tx_byte, tx_valid, eop, input tx_ready, eop_done);
    modport slave  (input tx_byte, tx_valid, eop, output tx_ready, eop_done);
endinterface

// File: rtl/txpu_gen2.sv
// USB transmit packet controller: handshake and DATA0/DATA1 packets with payload, CRC16 and EOP.
// Optional inter-packet gap state enabled by defining TXPU_GAP_EN.
module txpu_gen2 #(
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned LEN_W       = 7,
    parameter int unsigned IPG_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             send_hs,
    input  logic [1:0]       hs_pid,
    input  logic             send_data,
    input  logic [LEN_W-1:0] data_len,
    input  logic             data_ack,
    input  logic             toggle_clr,
    input  logic [7:0]       fifo_rdata,
    input  logic             fifo_empty,
    input  logic [15:0]      crc16_in,
    txpu_gen2_if.master      tx,
    output logic             fifo_r_enable,
    output logic             crc_clear,
    output logic             crc_calc,
    output logic             is_txing,
    output logic             toggle,
    output logic             underrun
);

`ifdef TXPU_GAP_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_GAP
    } state_t;
    localparam int unsigned GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
    } state_t;
`endif

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PAYLOAD);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic [1:0]       hs_sel;
    logic             is_hs;
    logic             chk_q;
    logic [7:0]       hs_byte;
    logic [7:0]       byte_mux;
    logic             valid_mux;
    logic             xfer;

    assign cnt_inc = cnt + LEN_W'(1);

    always_comb begin
        case (hs_sel)
            2'b00:   hs_byte = 8'hD2;
            2'b10:   hs_byte = 8'h1E;
            default: hs_byte = 8'h5A;
        endcase
    end

    // Payload bytes pass straight from the FWFT FIFO head so a pop lands in the transfer cycle.
    always_comb begin
        byte_mux  = 8'h00;
        valid_mux = 1'b0;
        case (state)
            S_SYNC:   begin byte_mux = 8'h80;          valid_mux = 1'b1; end
            S_PID:    begin
                byte_mux  = is_hs ? hs_byte : (toggle ? 8'h4B : 8'hC3);
                valid_mux = 1'b1;
            end
            S_DATA:   begin byte_mux = fifo_rdata;     valid_mux = !fifo_empty; end
            S_CRC_LO: begin byte_mux = crc16_in[7:0];  valid_mux = 1'b1; end
            S_CRC_HI: begin byte_mux = crc16_in[15:8]; valid_mux = 1'b1; end
            default:  ;
        endcase
    end

    assign tx.tx_byte    = byte_mux;
    assign tx.tx_valid   = valid_mux;
    assign tx.eop        = (state == S_EOP);
    assign is_txing      = (state != S_IDLE);
    assign xfer          = valid_mux && tx.tx_ready;
    assign fifo_r_enable = (state == S_DATA) && xfer;
    assign crc_calc      = (state == S_DATA) && xfer;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            cnt       <= '0;
            hs_sel    <= '0;
            is_hs     <= 1'b0;
            chk_q     <= 1'b0;
            crc_clear <= 1'b0;
            underrun  <= 1'b0;
`ifdef TXPU_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            crc_clear <= 1'b0;
            underrun  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (send_hs || send_data) begin
                        state     <= S_SYNC;
                        crc_clear <= 1'b1;
                        is_hs     <= send_hs;
                        hs_sel    <= hs_pid;
                        len_q     <= (data_len > LEN_MAX) ? LEN_MAX : data_len;
                        cnt       <= '0;
                    end
                end
                S_SYNC: if (xfer) state <= S_PID;
                S_PID: begin
                    if (xfer) begin
                        if (is_hs) begin
                            state <= S_EOP;
                        end else if (len_q != '0) begin
                            state <= S_DATA;
                            chk_q <= 1'b1;
                        end else begin
                            state <= S_CRC_LO;
                        end
                    end
                end
                // chk_q marks the cycles where an empty FIFO counts as underrun.
                S_DATA: begin
                    chk_q <= 1'b0;
                    if (chk_q && fifo_empty) begin
                        underrun <= 1'b1;
                        state    <= S_EOP;
                    end else if (xfer) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == len_q) state <= S_CRC_LO;
                        else                  chk_q <= 1'b1;
                    end
                end
                S_CRC_LO: if (xfer) state <= S_CRC_HI;
                S_CRC_HI: if (xfer) state <= S_EOP;
                S_EOP: begin
                    if (tx.eop_done) begin
`ifdef TXPU_GAP_EN
                        state   <= S_GAP;
                        gap_cnt <= GAP_W'(IPG_CYCLES - 1);
`else
                        state   <= S_IDLE;
`endif
                    end
                end
`ifdef TXPU_GAP_EN
                S_GAP: begin
                    if (gap_cnt == '0) state <= S_IDLE;
                    else               gap_cnt <= gap_cnt - GAP_W'(1);
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)          toggle <= 1'b0;
        else if (toggle_clr) toggle <= 1'b0;
        else if (data_ack)   toggle <= ~toggle;
    end

endmodule
